// File: rtl/theta_stage_pkg.sv
// Shared constants for the theta stage: slice geometry, state depth, FSM encoding.
package theta_stage_pkg;

  localparam int unsigned SLICE_W     = 25;
  localparam int unsigned STATE_DEPTH = 64;
  localparam int unsigned NUM_COLS    = 5;
  localparam int unsigned NUM_ROWS    = 5;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  // Bit position of lane (x, y) inside a slice.
  function automatic int unsigned bit_index(input int unsigned x, input int unsigned y);
    return NUM_COLS * y + x;
  endfunction

endpackage

// File: rtl/theta_stage_if.sv
// Slice stream bundle: upstream load port and downstream emit port.
interface theta_stage_if #(
  parameter int unsigned N = 25
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_slice;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_slice;
  logic         out_last;

  modport slave (
    input  in_valid, in_slice, out_ready,
    output in_ready, out_valid, out_slice, out_last
  );

  modport master (
    output in_valid, in_slice, out_ready,
    input  in_ready, out_valid, out_slice, out_last
  );
endinterface

// File: rtl/theta_column_parity.sv
// Combinational 5-bit column parity of one slice.
module theta_column_parity
  import theta_stage_pkg::*;
#(
  parameter int unsigned N = SLICE_W
) (
  input  logic [N-1:0] slice,
  output logic [4:0]   parity
);

  // XOR every row of each column together
  always_comb begin
    parity = '0;
    for (int unsigned y = 0; y < NUM_ROWS; y++) begin
      for (int unsigned x = 0; x < NUM_COLS; x++) begin
        if (bit_index(x, y) < N) parity[x] = parity[x] ^ slice[bit_index(x, y)];
      end
    end
  end

endmodule

// File: rtl/theta_stage.sv
// Theta step over a stream of slices: buffer a full state, then emit theta-mixed slices.
module theta_stage
  import theta_stage_pkg::*;
#(
  parameter int unsigned N     = SLICE_W,
  parameter int unsigned DEPTH = STATE_DEPTH
) (
  input logic        clk,
  input logic        rst,
  theta_stage_if.slave bus
);

  localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_Z = CW'(DEPTH - 1);

  logic [N-1:0] buffer_q [DEPTH];
  logic [4:0]   par_q    [DEPTH];

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] load_q, load_d;
  logic [CW-1:0] emit_q, emit_d;
  logic [N-1:0]  out_slice_q, out_slice_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          in_ready_q, in_ready_d;
  logic          wr_en_c;
  logic [4:0]    in_par_c;
  logic [CW-1:0] next_z_c;

  theta_column_parity #(.N(N)) u_parity (
    .slice  (bus.in_slice),
    .parity (in_par_c)
  );

  // One theta output slice from its own column parity and the previous slice's
  function automatic logic [N-1:0] theta(input logic [N-1:0] s,
                                         input logic [4:0]   cz,
                                         input logic [4:0]   cprev);
    logic [N-1:0] r;
    r = s;
    for (int unsigned y = 0; y < NUM_ROWS; y++) begin
      for (int unsigned x = 0; x < NUM_COLS; x++) begin
        if (bit_index(x, y) < N)
          r[bit_index(x, y)] = s[bit_index(x, y)] ^ cz[(x + 4) % 5] ^ cprev[(x + 1) % 5];
      end
    end
    return r;
  endfunction

  // Next-state, counter and output-register logic
  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    emit_d      = emit_q;
    out_slice_d = out_slice_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    in_ready_d  = in_ready_q;
    wr_en_c     = 1'b0;
    next_z_c    = emit_q + CW'(1);
    case (state_q)
      ST_LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          wr_en_c = 1'b1;
          if (load_q == LAST_Z) begin
            // slice 0 mixes with the last slice, which is arriving right now
            load_d      = '0;
            state_d     = ST_EMIT;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            out_slice_d = theta(buffer_q[0], par_q[0], in_par_c);
          end else begin
            load_d = load_q + CW'(1);
          end
        end
      end
      ST_EMIT: begin
        if (out_valid_q && bus.out_ready) begin
          if (out_last_q) begin
            state_d     = ST_LOAD;
            emit_d      = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            out_slice_d = '0;
          end else begin
            emit_d      = next_z_c;
            out_last_d  = (next_z_c == LAST_Z);
            out_slice_d = theta(buffer_q[next_z_c], par_q[next_z_c], par_q[emit_q]);
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      load_q      <= '0;
      emit_q      <= '0;
      out_slice_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      emit_q      <= emit_d;
      out_slice_q <= out_slice_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Slice and parity storage; always fully rewritten before being read
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      buffer_q[load_q] <= bus.in_slice;
      par_q[load_q]    <= in_par_c;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_slice = out_slice_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_theta_stage.sv
// Self-checking bench for theta_stage: table of frames plus backpressure and reset sequences.
module tb_theta_stage;

  localparam int unsigned N     = 25;
  localparam int unsigned DEPTH = 64;

  typedef struct {
    int          z;
    logic [24:0] val;
    logic        last;
  } exp_t;

  typedef struct {
    string       name;
    int          src_z;
    logic [24:0] src_val;
    int          chk_z0;
    logic [24:0] chk_v0;
    int          chk_z1;
    logic [24:0] chk_v1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  logic [24:0] frame [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  theta_stage_if #(.N(N)) bus ();

  theta_stage #(.N(N), .DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%07h expected 0x%07h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] col_par(input logic [24:0] s);
    return s[4:0] ^ s[9:5] ^ s[14:10] ^ s[19:15] ^ s[24:20];
  endfunction

  // Reference: rotate column parities and broadcast the 5-bit mix over all rows
  function automatic logic [24:0] model(input int z);
    logic [4:0] cz, cp, d;
    cz = col_par(frame[z]);
    cp = col_par(frame[(z + DEPTH - 1) % DEPTH]);
    d  = {cz[3:0], cz[4]} ^ {cp[0], cp[4:1]};
    return frame[z] ^ {d, d, d, d, d};
  endfunction

  task automatic load_frame();
    for (int z = 0; z < DEPTH; z++) begin
      @(negedge clk);
      if (z == 0) check("in_ready_load", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_slice = frame[z];
    end
    for (int z = 0; z < DEPTH; z++) begin
      exp_t e;
      e.z    = z;
      e.val  = model(z);
      e.last = (z == DEPTH - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int stall_z, input int abort_z,
                       input int chk_z0, input logic [24:0] chk_v0,
                       input int chk_z1, input logic [24:0] chk_v1);
    int cyc = 0;
    int stalls = 0;
    bit aborted = 0;
    while (sb.size() > 0 && cyc < 1000 && !aborted) begin
      exp_t e;
      @(negedge clk);
      cyc++;
      bus.in_valid = 1'b0;
      if (!bus.out_valid) begin
        bus.out_ready = 1'b1;
      end else begin
        e = sb[0];
        if (e.z == abort_z) begin
          rst = 1'b1;
          bus.out_ready = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          check("rst_in_ready", 32'(bus.in_ready), 32'd1);
          check("rst_out_valid", 32'(bus.out_valid), 32'd0);
          check("rst_out_slice", 32'(bus.out_slice), 32'd0);
          sb.delete();
          aborted = 1;
        end else if (e.z == stall_z && stalls < 3) begin
          stalls++;
          bus.out_ready = 1'b0;
          bus.in_valid  = 1'b1;
          bus.in_slice  = 25'($urandom);
          check("stall_slice", 32'(bus.out_slice), 32'(e.val));
          check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end else begin
          bus.out_ready = 1'b1;
          check($sformatf("slice_z%0d", e.z), 32'(bus.out_slice), 32'(e.val));
          check($sformatf("last_z%0d", e.z), 32'(bus.out_last), 32'(e.last));
          if (e.z == chk_z0) check("spot0", 32'(bus.out_slice), 32'(chk_v0));
          if (e.z == chk_z1) check("spot1", 32'(bus.out_slice), 32'(chk_v1));
          void'(sb.pop_front());
        end
      end
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    if (!aborted) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("back_out_valid", 32'(bus.out_valid), 32'd0);
      check("back_in_ready", 32'(bus.in_ready), 32'd1);
    end
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{"all_zero",   0, 25'h0,        63, 25'h0,       0, 25'h0};
    vecs[1] = '{"bit0_z0",    0, 25'h0000001,   0, 25'h0210843, 1, 25'h1084210};
    vecs[2] = '{"bit0_z63",  63, 25'h0000001,  63, 25'h0210843, 0, 25'h1084210};
    vecs[3] = '{"even_z5",    5, 25'h0000021,   5, 25'h0000021, 6, 25'h0};
    vecs[4] = '{"bit24_z30", 30, 25'h1000000,  30, 25'h1108421, 31, 25'h0842108};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_slice  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_last", 32'(bus.out_last), 32'd0);
    check("reset_out_slice", 32'(bus.out_slice), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      for (int z = 0; z < DEPTH; z++) frame[z] = '0;
      frame[vecs[i].src_z] = vecs[i].src_val;
      load_frame();
      drain(-1, -1, vecs[i].chk_z0, vecs[i].chk_v0, vecs[i].chk_z1, vecs[i].chk_v1);
    end

    // random frame with backpressure and ignored in_valid pulses at z=10
    for (int z = 0; z < DEPTH; z++) frame[z] = 25'($urandom);
    load_frame();
    drain(10, -1, -1, 25'h0, -1, 25'h0);

    // reset mid-emit, then a fresh frame must start from z=0
    for (int z = 0; z < DEPTH; z++) frame[z] = 25'($urandom);
    load_frame();
    drain(-1, 20, -1, 25'h0, -1, 25'h0);
    for (int z = 0; z < DEPTH; z++) frame[z] = '0;
    frame[0] = 25'h0000001;
    load_frame();
    drain(-1, -1, 0, 25'h0210843, 1, 25'h1084210);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/theta_stage.md
THETA_STAGE -- requirements
Module: theta_stage

Interface
REQ-001 Parameter N, default 25: slice width in bits; bit index = 5*y + x, x,y in 0..4.
REQ-002 Parameter DEPTH, default 64: slices per state (lane length); slice index z = arrival order 0..DEPTH-1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream presents a slice on in_slice.
REQ-006 in_ready  output  1  block accepts a slice this cycle.
REQ-007 in_slice  input  N  incoming slice.
REQ-008 out_valid  output  1  out_slice holds a valid theta-transformed slice.
REQ-009 out_ready  input  1  downstream accepts out_slice this cycle.
REQ-010 out_slice  output  N  transformed slice, registered.
REQ-011 out_last  output  1  high with out_valid on the slice with z = DEPTH-1.

Function
REQ-012 Transfer occurs on a cycle where valid and ready are both high, on either port; there are no other transfers.
REQ-013 FSM states: LOAD, EMIT.
- LOAD: in_ready=1, out_valid=0.
- EMIT: in_ready=0.
REQ-014 In LOAD, each accepted slice is written to buffer[z], where z = the load counter value; the counter then increments.
REQ-015 Also in LOAD, the 5-bit column parity C[x][z] = XOR over y of in_slice[5y+x] is stored for the accepted slice.
REQ-016 On acceptance of slice z = DEPTH-1: load counter wraps to 0, FSM goes to EMIT, and out_valid is high with slice 0 on the next cycle (1-cycle latency).
REQ-017 Output bit [5y+x] of slice z = buffer[z][5y+x] ^ C[(x+4)%5][z] ^ C[(x+1)%5][(z+DEPTH-1)%DEPTH].
REQ-018 In EMIT, out_slice and out_valid hold stable while out_ready=0.
REQ-019 On each output transfer, the emit counter increments and out_slice updates to the next slice on the following cycle, so back-to-back transfers run at 1 slice/cycle.
REQ-020 On the transfer with out_last=1:
- FSM returns to LOAD;
- out_valid=0 and in_ready=1 on the next cycle;
- emit counter wraps to 0.
REQ-021 in_valid is ignored in EMIT, with no buffer write and no counter change.
REQ-022 All XOR arithmetic is bitwise and width-exact; counters are log2(DEPTH) bits and wrap modulo DEPTH.

Reset
REQ-023 When rst=1 at a rising edge, the block enters:
- FSM = LOAD; both counters = 0;
- in_ready=1, out_valid=0, out_last=0, out_slice=0.
REQ-024 Reset in any state, including mid-load or mid-emit, discards the partial operation. The next accepted slice is z=0.
REQ-025 Buffer and parity contents need no reset; they are never output before being fully rewritten.

Structure
REQ-026 Shared package holds:
- SLICE_W=25 and STATE_DEPTH=64;
- the FSM state encoding;
- the bit-index helper constants (5*y+x).
REQ-027 Column parity (N-bit slice in, 5-bit parity out) is one combinational sub-module, theta_column_parity.
REQ-028 Load and emit indices use the existing counter block in increment mode; the output slice uses the existing register block.

Verification
REQ-029 All-zero input, 64 slices -> 64 output slices all 0x0000000; out_last only on the 64th output.
REQ-030 Single bit 0 set in slice 0, all others zero:
- out slice 0 = 0x0210843;
- out slice 1 = 0x1084210;
- all other out slices = 0.
REQ-031 Wrap-around: single bit 0 set in slice 63, all others zero:
- out slice 63 = 0x0210843;
- out slice 0 = 0x1084210;
- all other out slices = 0.
REQ-032 Even column parity: slice 5 = 0x0000021, all others zero -> output identical to input; out slice 5 = 0x0000021.
REQ-033 Backpressure: hold out_ready=0 for 3 cycles at output z=10 -> out_slice and out_valid unchanged over those cycles; in_valid pulses during EMIT cause no effect.
REQ-034 Reset mid-emit at z=20 -> next cycle in_ready=1, out_valid=0, out_slice=0; a new 64-slice load then emits correctly from z=0.
